// File: rtl/nvdla_dbb_req_arbiter_pkg.sv
// nvdla_package: shared state, request types and default widths for DBB request sharing
package nvdla_package;
    localparam int DBB_ADDR_W      = 64;
    localparam int DBB_LEN_W       = 13;
    localparam int DBB_ID_W        = 8;
    localparam int DBB_CNT_W       = 16;
    localparam int DBB_TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_dbb_arb_t;

    typedef struct packed {
        logic [DBB_ADDR_W-1:0] addr;
        logic [DBB_LEN_W-1:0]  len;
        logic [DBB_ID_W-1:0]   id;
        logic                  write;
    } dbb_req_t;
endpackage

// File: rtl/nvdla_dbb_req_arbiter_rr_arb2.sv
// nvdla_rr_arb2: two-way round-robin arbiter with last-grant pointer and grant enable
// Ports: clk_i/rst_ni (async active-low) clock and reset, clear_i soft clear,
//        en_i grant enable, req_i[1:0] requests, gnt_o[1:0] one-hot grant (comb).
// Pointer resets to requester 1, so requester 0 wins the first contention.
module nvdla_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;

    always_comb begin
        gnt_o[0] = en_i & req_i[0] & (~req_i[1] | last_q);
        gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_q);
        last_d   = |gnt_o ? gnt_o[1] : last_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= 1'b1;
        else         last_q <= clear_i ? 1'b1 : last_d;
    end
endmodule

// File: rtl/nvdla_dbb_req_arbiter.sv
// nvdla_dbb_req_arbiter: shares one DBB bridge between NVDLA write and read request channels
// Ports: clk_i, rst_ni (async active-low), clear_i (sync soft clear);
//        wr_req_* / rd_req_* upstream valid/ready request channels;
//        req_* forwarded request to the bridge; wr_done_i / rd_done_i completion pulses;
//        busy_o transaction in flight; wr_cnt_o / rd_cnt_o saturating completion counters.
// Optional: NVDLA_DBB_ARB_TIMEOUT_EN adds TIMEOUT_CYC and sticky timeout_o watchdog.
module nvdla_dbb_req_arbiter
    import nvdla_package::*;
#(
    parameter int ADDR_W = DBB_ADDR_W,
    parameter int LEN_W  = DBB_LEN_W,
    parameter int ID_W   = DBB_ID_W,
    parameter int CNT_W  = DBB_CNT_W
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = DBB_TIMEOUT_CYC
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_req_valid_i,
    output logic              wr_req_ready_o,
    input  logic [ADDR_W-1:0] wr_req_addr_i,
    input  logic [LEN_W-1:0]  wr_req_len_i,
    input  logic [ID_W-1:0]   wr_req_id_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_req_addr_i,
    input  logic [LEN_W-1:0]  rd_req_len_i,
    input  logic [ID_W-1:0]   rd_req_id_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_write_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [LEN_W-1:0]  req_len_o,
    output logic [ID_W-1:0]   req_id_o,
    input  logic              wr_done_i,
    input  logic              rd_done_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  rd_cnt_o
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
    , output logic            timeout_o
`endif
);
    state_dbb_arb_t   state_q, state_d;
    dbb_req_t         hold_q, hold_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]       gnt;
    logic             done, expired;

    // Grants are suppressed during clear so an accepted request is never lost to it.
    nvdla_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .en_i    (state_q == IDLE && !clear_i),
        .req_i   ({rd_req_valid_i, wr_req_valid_i}),
        .gnt_o   (gnt)
    );

    assign wr_req_ready_o = gnt[0];
    assign rd_req_ready_o = gnt[1];
    assign req_valid_o    = state_q == ISSUE;
    assign req_write_o    = hold_q.write;
    assign req_addr_o     = hold_q.addr;
    assign req_len_o      = hold_q.len;
    assign req_id_o       = hold_q.id;
    assign busy_o         = state_q != IDLE;
    assign wr_cnt_o       = wr_cnt_q;
    assign rd_cnt_o       = rd_cnt_q;
    assign done           = hold_q.write ? wr_done_i : rd_done_i;

`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;

    // Counter holds the number of completed WAIT_DONE cycles; the last one expires.
    assign expired   = state_q == WAIT_DONE && !done && tmo_q == TMO_W'(TIMEOUT_CYC - 1);
    assign timeout_o = timeout_q;

    always_comb begin
        tmo_d     = state_q == WAIT_DONE ? tmo_q + 1'b1 : '0;
        timeout_d = timeout_q | expired;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = ISSUE;
                hold_d  = gnt[0] ? dbb_req_t'{addr: wr_req_addr_i, len: wr_req_len_i, id: wr_req_id_i, write: 1'b1}
                                 : dbb_req_t'{addr: rd_req_addr_i, len: rd_req_len_i, id: rd_req_id_i, write: 1'b0};
            end
            ISSUE: if (req_ready_i) state_d = WAIT_DONE;
            WAIT_DONE: if (done) begin
                state_d  = IDLE;
                wr_cnt_d = hold_q.write ? wr_cnt_q + CNT_W'(~&wr_cnt_q) : wr_cnt_q;
                rd_cnt_d = hold_q.write ? rd_cnt_q : rd_cnt_q + CNT_W'(~&rd_cnt_q);
            end else if (expired) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
endmodule

// File: tb/tb_nvdla_dbb_req_arbiter.sv
// tb_nvdla_dbb_req_arbiter: randomized scoreboard bench with a transaction-level reference model
module tb_nvdla_dbb_req_arbiter;
    localparam int CW = 4;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif

    typedef struct packed {
        logic [63:0] a;
        logic [12:0] l;
        logic [7:0]  i;
        logic        w;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i;
    logic          wr_req_valid_i, wr_req_ready_o, rd_req_valid_i, rd_req_ready_o;
    logic [63:0]   wr_req_addr_i, rd_req_addr_i, req_addr_o;
    logic [12:0]   wr_req_len_i, rd_req_len_i, req_len_o;
    logic [7:0]    wr_req_id_i, rd_req_id_i, req_id_o;
    logic          req_valid_o, req_ready_i, req_write_o;
    logic          wr_done_i, rd_done_i, busy_o;
    logic [CW-1:0] wr_cnt_o, rd_cnt_o;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
    logic          timeout_o;
`endif

    always #5 clk_i = ~clk_i;

    nvdla_dbb_req_arbiter #(
        .CNT_W(CW)
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
        .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_write_o(req_write_o),
        .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_id_o(req_id_o),
        .wr_done_i(wr_done_i), .rd_done_i(rd_done_i), .busy_o(busy_o),
        .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    int   checks = 0, errors = 0;
    txn_t sb[$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Reference model: phase 0 = free, 1 = request offered to bridge, 2 = awaiting completion.
    int   m_ph, m_wc, m_rc, m_wait;
    bit   m_last_rd, m_wr, m_to;
    always @(negedge clk_i) begin
        bit   ew, er;
        txn_t t;
        if (!rst_ni) begin
            m_ph = 0; m_last_rd = 1; m_wc = 0; m_rc = 0; m_to = 0; m_wait = 0; sb.delete();
        end else begin
            ew = m_ph == 0 && !clear_i && wr_req_valid_i && (!rd_req_valid_i || m_last_rd);
            er = m_ph == 0 && !clear_i && rd_req_valid_i && !ew;
            chk("wr_req_ready", wr_req_ready_o, ew);
            chk("rd_req_ready", rd_req_ready_o, er);
            chk("req_valid", req_valid_o, m_ph == 1);
            chk("busy", busy_o, m_ph != 0);
            chk("wr_cnt", wr_cnt_o, m_wc);
            chk("rd_cnt", rd_cnt_o, m_rc);
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
            chk("timeout", timeout_o, m_to);
`endif
            if (clear_i) begin
                m_ph = 0; m_last_rd = 1; m_wc = 0; m_rc = 0; m_to = 0; sb.delete();
            end else if (m_ph == 0) begin
                if (ew || er) begin
                    if (ew) t = '{wr_req_addr_i, wr_req_len_i, wr_req_id_i, 1'b1};
                    else    t = '{rd_req_addr_i, rd_req_len_i, rd_req_id_i, 1'b0};
                    sb.push_back(t);
                    m_wr = ew; m_last_rd = er; m_ph = 1;
                end
            end else if (m_ph == 1) begin
                if (req_ready_i) begin m_ph = 2; m_wait = 0; end
            end else if (m_wr ? wr_done_i : rd_done_i) begin
                m_ph = 0;
                if (m_wr) m_wc = m_wc == (1 << CW) - 1 ? m_wc : m_wc + 1;
                else      m_rc = m_rc == (1 << CW) - 1 ? m_rc : m_rc + 1;
            end
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin m_ph = 0; m_to = 1; end
            end
`endif
        end
    end

    // Monitor: the offered bridge request must match the oldest granted transaction every cycle.
    always @(negedge clk_i) begin
        if (rst_ni && !clear_i && req_valid_o) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got request id %0h, expected none", req_id_o);
            end else begin
                chk("req_addr", req_addr_o, sb[0].a);
                chk("req_len", req_len_o, sb[0].l);
                chk("req_id", req_id_o, sb[0].i);
                chk("req_write", req_write_o, sb[0].w);
                if (req_ready_i) void'(sb.pop_front());
            end
        end
    end

    // Bridge responder with knobs for backpressure, done latency, wrong/spurious dones, no done.
    int rdy_pct = 100, wrong_pct = 0, dmin = 0, dmax = 0;
    bit no_done = 0;
    initial begin
        bit pend, pw, hs;
        int dly;
        req_ready_i = 0; wr_done_i = 0; rd_done_i = 0; pend = 0; pw = 0; dly = 0;
        forever begin
            @(negedge clk_i);
            hs = req_valid_o && req_ready_i;
            if (!rst_ni || clear_i || !busy_o) pend = 0;
            else if (hs) begin pend = 1; pw = req_write_o; dly = $urandom_range(dmin, dmax); end
            @(posedge clk_i); #1;
            req_ready_i = $urandom_range(0, 99) < rdy_pct;
            wr_done_i = 0; rd_done_i = 0;
            if (pend && !no_done && dly == 0) begin
                pend = 0;
                if (pw) wr_done_i = 1; else rd_done_i = 1;
            end else begin
                if (pend && dly > 0) dly--;
                if ($urandom_range(0, 99) < wrong_pct) begin
                    if (pend) begin if (pw) rd_done_i = 1; else wr_done_i = 1; end
                    else if (!hs) begin if ($urandom_range(0, 1) == 1) wr_done_i = 1; else rd_done_i = 1; end
                end
            end
        end
    end

    task automatic set_wr(input logic [63:0] a, input logic [12:0] l, input logic [7:0] i);
        wr_req_valid_i = 1; wr_req_addr_i = a; wr_req_len_i = l; wr_req_id_i = i;
    endtask

    task automatic set_rd(input logic [63:0] a, input logic [12:0] l, input logic [7:0] i);
        rd_req_valid_i = 1; rd_req_addr_i = a; rd_req_len_i = l; rd_req_id_i = i;
    endtask

    // Upstream driver: holds valid until accepted, then issues a new request with probability wp/rp.
    task automatic run(input int n, input int wp, input int rp, input int cp);
        bit wa, ra;
        repeat (n) begin
            @(negedge clk_i);
            wa = wr_req_ready_o; ra = rd_req_ready_o;
            @(posedge clk_i); #1;
            clear_i = $urandom_range(0, 999) < cp;
            if (wa || !wr_req_valid_i) begin
                if ($urandom_range(0, 99) < wp) set_wr({$urandom, $urandom}, 13'($urandom), 8'($urandom));
                else wr_req_valid_i = 0;
            end
            if (ra || !rd_req_valid_i) begin
                if ($urandom_range(0, 99) < rp) set_rd({$urandom, $urandom}, 13'($urandom), 8'($urandom));
                else rd_req_valid_i = 0;
            end
        end
    endtask

    initial begin
        rst_ni = 0; clear_i = 0;
        wr_req_valid_i = 0; wr_req_addr_i = 0; wr_req_len_i = 0; wr_req_id_i = 0;
        rd_req_valid_i = 0; rd_req_addr_i = 0; rd_req_len_i = 0; rd_req_id_i = 0;
        run(3, 0, 0, 0);
        rst_ni = 1;
        run(2, 0, 0, 0);
        set_wr(64'h1000, 13'd3, 8'd5);
        run(10, 0, 0, 0);
        repeat (3) begin
            set_wr({$urandom, $urandom}, 13'($urandom), 8'($urandom));
            set_rd({$urandom, $urandom}, 13'($urandom), 8'($urandom));
            run(16, 0, 0, 0);
        end
        rdy_pct = 0;
        set_wr(64'h2000, 13'd7, 8'h11);
        set_rd(64'h3000, 13'd9, 8'h22);
        run(6, 0, 0, 0);
        rdy_pct = 100;
        run(16, 0, 0, 0);
        wrong_pct = 100; dmin = 4; dmax = 4;
        set_wr(64'h4000, 13'd1, 8'h33);
        set_rd(64'h5000, 13'd2, 8'h44);
        run(26, 0, 0, 0);
        wrong_pct = 0; dmin = 10; dmax = 10;
        set_wr(64'h6000, 13'd4, 8'h55);
        run(4, 0, 0, 0);
        clear_i = 1;
        run(6, 0, 0, 0);
        dmin = 0; dmax = 2;
        run(120, 100, 0, 0);
        run(120, 0, 100, 0);
        run(10, 0, 0, 0);
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
        no_done = 1;
        set_wr(64'h7000, 13'd5, 8'h66);
        run(30, 0, 0, 0);
        no_done = 0;
`endif
        rdy_pct = 60; wrong_pct = 20; dmax = 5;
        run(1500, 40, 40, 3);
        rst_ni = 0;
        run(2, 0, 0, 0);
        rst_ni = 1;
        run(1500, 40, 40, 3);
        rdy_pct = 100; wrong_pct = 0;
        run(20, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
